snn_debug_readout_ctrl: RTL and testbench

Controller sitting in front of the debug spike FIFO (fifo_spi_snn). It shares the FIFO write port between NUM_SRC SNN layer requesters using round-robin arbitration, tagging each word with its source ID. It sequences serial readout by holding the FIFO read enable for exactly one frame per word and generating an SPI-style chip-select. It also counts words lost to FIFO overflow or overwrite-while-shifting errors.

---
 rtl/snn_debug_pkg.sv | 34 +++
 rtl/snn_rr_arbiter.sv | 54 +++++
 rtl/snn_debug_readout_ctrl.sv | 177 +++++++++++++++++
 tb/tb_snn_debug_readout_ctrl.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/snn_debug_pkg.sv
// ---------------------------------------------------------------------------
// snn_debug_pkg
// Shared definitions for the SNN debug readout controller:
//   - read FSM state encoding (IDLE, SHIFT, GAP)
//   - id_width()  : source-tag width for a given requester count
//   - frame_len() : serial frame length in clock cycles
//   - sat_add()   : saturating add used by the drop counter
// ---------------------------------------------------------------------------
package snn_debug_pkg;

   typedef logic [1:0] rd_state_t;

   localparam rd_state_t RD_IDLE  = 2'd0;
   localparam rd_state_t RD_SHIFT = 2'd1;
   localparam rd_state_t RD_GAP   = 2'd2;

   function automatic int id_width(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

   function automatic int frame_len(input int data_width, input int padding);
      return data_width + padding;
   endfunction

   // Adds b to a and clamps the result at max_val.
   function automatic logic [31:0] sat_add(input logic [31:0] a,
                                           input logic [31:0] b,
                                           input logic [31:0] max_val);
      logic [32:0] sum;
      sum = {1'b0, a} + {1'b0, b};
      return (sum > {1'b0, max_val}) ? max_val : sum[31:0];
   endfunction

endpackage

// File: rtl/snn_rr_arbiter.sv
// ---------------------------------------------------------------------------
// snn_rr_arbiter
// Round-robin arbiter with a registered priority pointer.
//   clk, rst_ni : clock, asynchronous active-low reset
//   req         : per-requester request vector
//   en          : arbitration enable; grant stays zero when low
//   grant       : one-hot grant, combinational
//   grant_idx   : binary index of the granted requester
// The search starts one above the last granted index, so a requester that
// holds its request is only served again after every other active one.
// ---------------------------------------------------------------------------
module snn_rr_arbiter
   import snn_debug_pkg::*;
#(
   parameter  int N  = 4,
   localparam int IW = id_width(N)
) (
   input  logic          clk,
   input  logic          rst_ni,
   input  logic [N-1:0]  req,
   input  logic          en,
   output logic [N-1:0]  grant,
   output logic [IW-1:0] grant_idx
);

   logic [IW-1:0] ptr_q, ptr_d;
   logic [IW-1:0] idx;
   logic          found;

   always_comb begin
      grant     = '0;
      grant_idx = '0;
      ptr_d     = ptr_q;
      idx       = '0;
      found     = 1'b0;
      // Offsets 1..N visit every requester once, ending at the pointer itself.
      for (int i = 1; i <= N; i++) begin
         idx = IW'((int'(ptr_q) + i) % N);
         if (en && !found && req[idx]) begin
            found      = 1'b1;
            grant[idx] = 1'b1;
            grant_idx  = idx;
            ptr_d      = idx;
         end
      end
   end

   // Reset pointer to the last index so requester 0 wins first.
   always_ff @(posedge clk or negedge rst_ni) begin
      if (!rst_ni) ptr_q <= IW'(N - 1);
      else         ptr_q <= ptr_d;
   end

endmodule

// File: rtl/snn_debug_readout_ctrl.sv
// ---------------------------------------------------------------------------
// snn_debug_readout_ctrl
// Front-end controller for the debug spike FIFO.
//   Write side : round-robin shares the FIFO write port between NUM_SRC layer
//                requesters (req_i/data_i/grant_o) and issues a registered
//                write {src_id, payload} one cycle after each grant
//                (fifo_wdata_o, fifo_write_en_o).
//   Read side  : holds fifo_read_en_o for one full frame per word, drives an
//                active-low frame select aligned to the FIFO's registered
//                serial output (spi_cs_n_o), pulses frame_done_o on the last
//                bit and reports busy_o while the read FSM is not idle.
//   Monitoring : drop_cnt_o counts words lost to overflow (write while full
//                without a concurrent read) or to fifo_error_i rising edges;
//                saturating, cleared by clr_cnt_i.
//   Enables    : snn_en gates grants, debug_en gates the start of new frames.
// ---------------------------------------------------------------------------
module snn_debug_readout_ctrl
   import snn_debug_pkg::*;
#(
   parameter  int NUM_SRC    = 4,
   parameter  int DATA_WIDTH = 16,
   parameter  int PADDING    = 0,
   parameter  int GAP_CYCLES = 2,
   parameter  int CNT_WIDTH  = 8,
   localparam int ID_W       = id_width(NUM_SRC),
   localparam int PAYLOAD_W  = DATA_WIDTH - ID_W
) (
   input  logic                           clk,
   input  logic                           rst_ni,
   input  logic                           snn_en,
   input  logic                           debug_en,
   input  logic [NUM_SRC-1:0]             req_i,
   input  logic [NUM_SRC*PAYLOAD_W-1:0]   data_i,
   output logic [NUM_SRC-1:0]             grant_o,
   output logic [DATA_WIDTH-1:0]          fifo_wdata_o,
   output logic                           fifo_write_en_o,
   output logic                           fifo_read_en_o,
   input  logic                           fifo_full_i,
   input  logic                           fifo_empty_i,
   input  logic                           fifo_error_i,
   output logic                           spi_cs_n_o,
   output logic                           frame_done_o,
   output logic                           busy_o,
   output logic [CNT_WIDTH-1:0]           drop_cnt_o,
   input  logic                           clr_cnt_i
);

   localparam int FRAME_LEN = frame_len(DATA_WIDTH, PADDING);
   localparam int TMR_MAX   = (FRAME_LEN > GAP_CYCLES) ? FRAME_LEN : GAP_CYCLES;
   localparam int TMR_W     = $clog2(TMR_MAX + 1);
   localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

   // ------------------------------------------------------------------ write
   logic [NUM_SRC-1:0]    grant;
   logic [ID_W-1:0]       grant_idx;
   logic [PAYLOAD_W-1:0]  payload [NUM_SRC];
   logic                  wr_en_q, wr_en_d;
   logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;

   for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_payload
      assign payload[gi] = data_i[gi*PAYLOAD_W +: PAYLOAD_W];
   end

   // Reset also masks the combinational grant so grant_o is zero in reset.
   snn_rr_arbiter #(.N(NUM_SRC)) u_arb (
      .clk       (clk),
      .rst_ni    (rst_ni),
      .req       (req_i),
      .en        (snn_en & rst_ni),
      .grant     (grant),
      .grant_idx (grant_idx)
   );

   assign grant_o   = grant;
   assign wr_en_d   = |grant;
   assign wr_data_d = (|grant) ? {grant_idx, payload[grant_idx]} : wr_data_q;

   always_ff @(posedge clk or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_en_q   <= 1'b0;
         wr_data_q <= '0;
      end else begin
         wr_en_q   <= wr_en_d;
         wr_data_q <= wr_data_d;
      end
   end

   assign fifo_write_en_o = wr_en_q;
   assign fifo_wdata_o    = wr_data_q;

   // ------------------------------------------------------------------- read
   rd_state_t        state_q, state_d;
   logic [TMR_W-1:0] tmr_q, tmr_d;
   logic             cs_n_q, cs_n_d;
   logic             done_q, done_d;
   logic             shift_last;

   assign shift_last = (state_q == RD_SHIFT) && (tmr_q == '0);

   always_comb begin
      state_d = state_q;
      tmr_d   = tmr_q;
      case (state_q)
         RD_IDLE: begin
            if (debug_en && !fifo_empty_i) begin
               state_d = RD_SHIFT;
               tmr_d   = TMR_W'(FRAME_LEN - 1);
            end
         end
         // Once started, a frame always runs to completion.
         RD_SHIFT: begin
            if (tmr_q == '0) begin
               state_d = RD_GAP;
               tmr_d   = TMR_W'(GAP_CYCLES - 1);
            end else begin
               tmr_d = tmr_q - TMR_W'(1);
            end
         end
         RD_GAP: begin
            if (tmr_q == '0) state_d = RD_IDLE;
            else             tmr_d   = tmr_q - TMR_W'(1);
         end
         default: state_d = RD_IDLE;
      endcase
   end

   // Frame select and done pulse trail read_en by one cycle, matching the
   // FIFO's registered serial data.
   assign cs_n_d = (state_q != RD_SHIFT);
   assign done_d = shift_last;

   always_ff @(posedge clk or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= RD_IDLE;
         tmr_q   <= '0;
         cs_n_q  <= 1'b1;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         tmr_q   <= tmr_d;
         cs_n_q  <= cs_n_d;
         done_q  <= done_d;
      end
   end

   assign fifo_read_en_o = (state_q == RD_SHIFT);
   assign spi_cs_n_o     = cs_n_q;
   assign frame_done_o   = done_q;
   assign busy_o         = (state_q != RD_IDLE);

   // ------------------------------------------------------------ drop count
   logic                 err_q;
   logic                 ovf_evt, err_evt;
   logic [1:0]           inc;
   logic [CNT_WIDTH-1:0] drop_q, drop_d;

   // A concurrent read frees a slot, so a write while full is only a loss
   // when no frame is being shifted out.
   assign ovf_evt = wr_en_q && fifo_full_i && !fifo_read_en_o;
   assign err_evt = fifo_error_i && !err_q;
   assign inc     = {1'b0, ovf_evt} + {1'b0, err_evt};
   assign drop_d  = clr_cnt_i ? '0
                  : CNT_WIDTH'(sat_add(32'(drop_q), 32'(inc), 32'(CNT_MAX)));

   always_ff @(posedge clk or negedge rst_ni) begin
      if (!rst_ni) begin
         err_q  <= 1'b0;
         drop_q <= '0;
      end else begin
         err_q  <= fifo_error_i;
         drop_q <= drop_d;
      end
   end

   assign drop_cnt_o = drop_q;

endmodule

// File: tb/tb_snn_debug_readout_ctrl.sv
// Testbench for snn_debug_readout_ctrl (default parameters, 32-deep FIFO stub).
// A timeline reference model predicts every output each cycle; directed
// sequences add explicit checks on frame shape, round-robin order and the
// drop counter, followed by a randomized phase.
module tb_snn_debug_readout_ctrl;

   localparam int N     = 4;
   localparam int DW    = 16;
   localparam int IDW   = 2;
   localparam int PW    = DW - IDW;
   localparam int F     = 16;
   localparam int GAP   = 2;
   localparam int DEPTH = 32;
   localparam int HMAX  = 8192;

   logic            clk = 1'b0;
   logic            rst_ni = 1'b0;
   logic            snn_en = 1'b0;
   logic            debug_en = 1'b0;
   logic [N-1:0]    req_i = '0;
   logic [N*PW-1:0] data_i = '0;
   logic            fifo_full_i = 1'b0;
   logic            fifo_empty_i = 1'b1;
   logic            fifo_error_i = 1'b0;
   logic            clr_cnt_i = 1'b0;
   logic [N-1:0]    grant_o;
   logic [DW-1:0]   fifo_wdata_o;
   logic            fifo_write_en_o;
   logic            fifo_read_en_o;
   logic            spi_cs_n_o;
   logic            frame_done_o;
   logic            busy_o;
   logic [7:0]      drop_cnt_o;

   always #5 clk = ~clk;

   snn_debug_readout_ctrl dut (
      .clk             (clk),
      .rst_ni          (rst_ni),
      .snn_en          (snn_en),
      .debug_en        (debug_en),
      .req_i           (req_i),
      .data_i          (data_i),
      .grant_o         (grant_o),
      .fifo_wdata_o    (fifo_wdata_o),
      .fifo_write_en_o (fifo_write_en_o),
      .fifo_read_en_o  (fifo_read_en_o),
      .fifo_full_i     (fifo_full_i),
      .fifo_empty_i    (fifo_empty_i),
      .fifo_error_i    (fifo_error_i),
      .spi_cs_n_o      (spi_cs_n_o),
      .frame_done_o    (frame_done_o),
      .busy_o          (busy_o),
      .drop_cnt_o      (drop_cnt_o),
      .clr_cnt_i       (clr_cnt_i)
   );

   int n_checks = 0;
   int n_errors = 0;
   int t = 0;
   int n_frames = 0;

   // Reference model: frames are described by their start cycle; everything
   // else is derived from that cycle and the frame/gap lengths.
   int            start_t = -1000;
   int            idle_from = 0;
   int            rr_last = N - 1;
   logic          m_we = 1'b0;
   logic [DW-1:0] m_wdata = '0;
   int            m_cnt = 0;
   logic          m_err_prev = 1'b0;
   int            occ = 0;

   logic          h_rd   [HMAX];
   logic          h_cs   [HMAX];
   logic          h_done [HMAX];
   logic [N-1:0]  obs_grant;
   logic          obs_we, obs_busy;
   logic [DW-1:0] obs_wdata;
   logic [7:0]    obs_drop;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, t);
      end
   endtask

   task automatic model_reset();
      start_t    = -1000;
      idle_from  = t;
      rr_last    = N - 1;
      m_we       = 1'b0;
      m_wdata    = '0;
      m_cnt      = 0;
      m_err_prev = 1'b0;
   endtask

   // One clock period: inputs already driven by the caller.
   task automatic step();
      logic [N-1:0] eg;
      int gidx, c, ovf, er, pop, sum;
      logic rd_e, cs_low, dn, bz;
      fifo_full_i  = (occ >= DEPTH);
      fifo_empty_i = (occ == 0);
      eg = '0;
      gidx = -1;
      if (snn_en) begin
         for (int k = 1; k <= N; k++) begin
            c = (rr_last + k) % N;
            if (gidx < 0 && req_i[c]) begin
               gidx  = c;
               eg[c] = 1'b1;
            end
         end
      end
      rd_e   = (t >= start_t) && (t < start_t + F);
      cs_low = (t > start_t) && (t <= start_t + F);
      dn     = (t == start_t + F);
      bz     = (t >= start_t) && (t < start_t + F + GAP);
      @(negedge clk);
      obs_grant = grant_o;
      obs_we    = fifo_write_en_o;
      obs_wdata = fifo_wdata_o;
      obs_busy  = busy_o;
      obs_drop  = drop_cnt_o;
      if (t < HMAX) begin
         h_rd[t]   = fifo_read_en_o;
         h_cs[t]   = spi_cs_n_o;
         h_done[t] = frame_done_o;
      end
      check("grant", grant_o, eg);
      check("wr_en", fifo_write_en_o, m_we);
      check("wdata", fifo_wdata_o, m_wdata);
      check("rd_en", fifo_read_en_o, rd_e);
      check("cs_n", spi_cs_n_o, !cs_low);
      check("done", frame_done_o, dn);
      check("busy", busy_o, bz);
      check("drop", drop_cnt_o, m_cnt);
      if (frame_done_o) begin
         n_frames++;
         $display("frame %0d done at cycle %0d, drop_cnt=%0d", n_frames, t, drop_cnt_o);
      end
      ovf = (m_we && fifo_full_i && !rd_e) ? 1 : 0;
      er  = (fifo_error_i && !m_err_prev) ? 1 : 0;
      m_err_prev = fifo_error_i;
      sum = m_cnt + ovf + er;
      m_cnt = clr_cnt_i ? 0 : ((sum > 255) ? 255 : sum);
      pop = (t == start_t) ? 1 : 0;
      if (t >= idle_from && debug_en && !fifo_empty_i) begin
         start_t   = t + 1;
         idle_from = t + 1 + F + GAP;
      end
      occ = occ - pop + (m_we ? 1 : 0);
      if (occ > DEPTH) occ = DEPTH;
      m_we = (gidx >= 0);
      if (gidx >= 0) begin
         m_wdata = {gidx[IDW-1:0], data_i[gidx*PW +: PW]};
         rr_last = gidx;
      end
      @(posedge clk);
      #1;
      t++;
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   // Step until a read_en rising edge is seen; leaves the bench in bit 1.
   task automatic wait_frame_start(input string tag, output int s);
      s = -1;
      for (int i = 0; i < 200 && s < 0; i++) begin
         step();
         if (t >= 2 && h_rd[t-1] && !h_rd[t-2]) s = t - 1;
      end
      if (s < 0) check(tag, 0, 1);
   endtask

   // Asynchronous reset in the middle of the current period.
   task automatic async_reset();
      #2;
      rst_ni = 1'b0;
      #1;
      check("rst_rd_en", fifo_read_en_o, 0);
      check("rst_cs_n", spi_cs_n_o, 1);
      check("rst_busy", busy_o, 0);
      check("rst_done", frame_done_o, 0);
      check("rst_wr_en", fifo_write_en_o, 0);
      check("rst_drop", drop_cnt_o, 0);
      if (t < HMAX) begin
         h_rd[t] = 1'b0;
         h_cs[t] = 1'b1;
         h_done[t] = 1'b0;
      end
      @(posedge clk);
      #1;
      t++;
      rst_ni = 1'b1;
      model_reset();
   endtask

   // Frame shape from recorded history: read_en run, cs_n window, done
   // position, and either the gap to the next frame or no further frame.
   task automatic analyze(input string tag, input int from, input int to, input bit expect_next);
      int s, len, lowlen, nxt;
      s = -1;
      for (int i = from; i <= to; i++) if (s < 0 && h_rd[i]) s = i;
      if (s < 0) begin
         check({tag, "_start"}, 0, 1);
         return;
      end
      len = 0;
      for (int i = s; i <= to && h_rd[i]; i++) len++;
      check({tag, "_rd_len"}, len, F);
      check({tag, "_cs_entry"}, h_cs[s], 1);
      lowlen = 0;
      for (int i = s + 1; i <= to && !h_cs[i]; i++) lowlen++;
      check({tag, "_cs_len"}, lowlen, F);
      check({tag, "_done_last"}, h_done[s+F], 1);
      check({tag, "_done_early"}, h_done[s+F-1], 0);
      nxt = -1;
      for (int i = s + F; i <= to; i++) if (nxt < 0 && h_rd[i]) nxt = i;
      if (expect_next) check({tag, "_gap"}, nxt - (s + F) - 1, GAP);
      else             check({tag, "_no_restart"}, nxt, -1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", t);
      $fatal(1, "watchdog");
   end

   initial begin
      int mark, s;
      for (int i = 0; i < HMAX; i++) begin
         h_rd[i] = 1'b0;
         h_cs[i] = 1'b1;
         h_done[i] = 1'b0;
      end

      // Reset with requests pending: grant must still be zero.
      snn_en = 1'b1;
      req_i  = '1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset_grant", grant_o, 0);
      check("reset_wr_en", fifo_write_en_o, 0);
      check("reset_wdata", fifo_wdata_o, 0);
      check("reset_rd_en", fifo_read_en_o, 0);
      check("reset_cs_n", spi_cs_n_o, 1);
      check("reset_busy", busy_o, 0);
      check("reset_drop", drop_cnt_o, 0);
      @(posedge clk);
      #1;
      rst_ni = 1'b1;
      req_i  = '0;
      t = 0;
      model_reset();

      // Single requester 2 with payload 0x1234.
      req_i = 4'b0100;
      data_i[2*PW +: PW] = 14'h1234;
      step();
      check("tp1_grant", obs_grant, 4'b0100);
      req_i = '0;
      step();
      check("tp1_wr_en", obs_we, 1);
      check("tp1_wdata", obs_wdata, 16'h9234);

      // Second word, then two back-to-back frames.
      req_i = 4'b0001;
      data_i[0 +: PW] = 14'h0abc;
      step();
      req_i = '0;
      step();
      debug_en = 1'b1;
      mark = t;
      steps(50);
      analyze("frame", mark, t - 1, 1'b1);

      // Reset at bit 7 of a frame.
      req_i = 4'b0010;
      step();
      req_i = '0;
      wait_frame_start("wait_rst_frame", s);
      steps(6);
      async_reset();
      step();
      check("release_busy", obs_busy, 0);

      // Round robin with all requests held; a fresh frame follows.
      mark = t;
      req_i = '1;
      data_i = (N*PW)'({$urandom(), $urandom()});
      for (int i = 0; i < 8; i++) begin
         step();
         check("rr_seq", obs_grant, 4'b0001 << (i % 4));
      end
      snn_en = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         check("snn_off_grant", obs_grant, 0);
      end
      req_i = '0;
      steps(40);
      analyze("fresh", mark, t - 1, 1'b1);

      // debug_en dropped at bit 3: frame completes, nothing new starts.
      wait_frame_start("wait_dbg_frame", s);
      steps(2);
      debug_en = 1'b0;
      steps(50);
      if (s >= 0) analyze("dbg_drop", s, t - 1, 1'b0);

      // Drain the FIFO, then overflow it with debug_en low.
      debug_en = 1'b1;
      for (int i = 0; i < 1000 && !(occ == 0 && t >= idle_from); i++) step();
      check("drain", occ, 0);
      debug_en  = 1'b0;
      clr_cnt_i = 1'b1;
      step();
      clr_cnt_i = 1'b0;
      snn_en = 1'b1;
      req_i  = 4'b0010;
      steps(33);
      req_i = '0;
      steps(2);
      check("ovf_first", obs_drop, 1);
      req_i = 4'b0010;
      steps(300);
      req_i = '0;
      steps(2);
      check("ovf_sat", obs_drop, 255);
      clr_cnt_i = 1'b1;
      step();
      clr_cnt_i = 1'b0;
      step();
      check("clr", obs_drop, 0);

      // Randomized traffic on both sides.
      for (int i = 0; i < 1500; i++) begin
         snn_en       = ($urandom_range(0, 7) != 0);
         debug_en     = ($urandom_range(0, 3) != 0);
         req_i        = N'($urandom());
         data_i       = (N*PW)'({$urandom(), $urandom()});
         fifo_error_i = ($urandom_range(0, 5) == 0);
         clr_cnt_i    = ($urandom_range(0, 99) == 0);
         step();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
